alarm_ring_multi: RTL
=====================

Name: alarm_ring_multi

Overview:
- Multi-slot alarm comparator and ring controller for the digital clock. Next generation of the single-alarm ring block.
- Holds N_ALARM programmable BCD alarm times and compares each against the running clock time.
- Drives a ring output with auto-timeout, dismiss and bounded snooze. Sits between the time-keeping counter and the buzzer/display driver.

Parameters:
- DATA_W, 16, alarm/time word width (BCD hh:mm, e.g. 16'h1234 = 12:34).
- N_ALARM, 4, number of alarm slots (1..8).
- IDX_W, 2, slot index width, must be ≥ clog2(N_ALARM).
- RING_TICKS, 60, ticks the alarm rings before auto-off (≥1).
- SNOOZE_TICKS, 300, ticks spent silent in snooze before re-ring (≥1).
- MAX_SNOOZE, 3, snoozes allowed per alarm event; the next snooze request acts as stop.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  write strobe for slot load_idx.
- load_idx  in  IDX_W  slot to write; values ≥ N_ALARM are ignored.
- load_en  in  1  enable bit written with the slot (0 = slot disarmed).
- data_in_load  in  DATA_W  alarm time written to the slot.
- data_in_cmp  in  DATA_W  current clock time.
- tick  in  1  single-cycle timebase pulse (1 Hz in system).
- stop  in  1  dismiss pulse.
- snooze  in  1  snooze pulse.
- ring  out  1  buzzer enable.
- ring_idx  out  IDX_W  slot currently ringing or snoozed.
- data_ring  out  DATA_W  alarm time of the active slot.
- snoozing  out  1  high while in SNOOZE.
- snooze_cnt  out  2  snoozes used in the current event.

Behaviour:
- Reset (rst=1 at clock edge): all slots cleared to 0 and disarmed, state IDLE. ring=0, ring_idx=0, data_ring=0, snoozing=0, snooze_cnt=0, tick counter=0. Reset overrides every other input, including mid-ring and mid-snooze.
- Load: on load=1 with a valid index, slot[load_idx] <= data_in_load and armed[load_idx] <= load_en, effective the next cycle. A load to the active slot while RINGING or SNOOZE updates storage only; the event continues and data_ring holds its latched value.
- Match: match[i] = armed[i] && slot[i]==data_in_cmp. Match vectors are registered each cycle (including during RINGING/SNOOZE, so prev reflects the last cycle). A trigger is a rising edge only: match[i] && !match_prev[i]. An alarm fires once per time-equality window and does not re-fire after stop while time is still equal.
- Priority: on simultaneous triggers, the lowest index wins. Other triggers that cycle are dropped.
- State IDLE: on a trigger, go to RINGING next cycle. Latch ring_idx and data_ring, clear the tick counter and snooze_cnt. Latency: trigger seen at edge t gives ring=1 after edge t+1.
- State RINGING: ring=1. Each tick increments the counter. When the counter reaches RING_TICKS, go to IDLE (ring=0 next cycle).
  - stop: go to IDLE.
  - snooze with snooze_cnt < MAX_SNOOZE: go to SNOOZE, snooze_cnt+1, counter cleared.
  - snooze with snooze_cnt == MAX_SNOOZE: treated as stop.
  - stop and snooze in the same cycle: stop wins.
  - tick and stop/snooze in the same cycle: stop/snooze wins.
- State SNOOZE: ring=0, snoozing=1. Count ticks. At SNOOZE_TICKS, go to RINGING with the counter cleared.
  - stop: go to IDLE and clear snooze_cnt.
  - snooze is ignored in this state.
- New triggers while RINGING/SNOOZE are ignored, not queued.
- Disarming the active slot (load_en=0) does not end the event.
- Counter width must hold max(RING_TICKS, SNOOZE_TICKS) without wrap.
- ring_idx and data_ring hold their last values in IDLE. snoozing is 0 outside SNOOZE.

Test Plan:
- Reset, then load slot0=16'h1234 with en=1. Drive data_in_cmp 16'h1233 → 16'h1234. Expect ring=1 one cycle after the cmp change, ring_idx=0, data_ring=16'h1234.
- With RING_TICKS=3 and no stop, apply 3 tick pulses. Expect ring to drop the cycle after the 3rd tick. Hold cmp=16'h1234 and expect no re-fire.
- Load slot1 and slot2 both =16'h0700 and step cmp to 16'h0700. Expect ring_idx=1. Stop, then confirm slot2 does not ring during the same equality window.
- During ring, pulse snooze with SNOOZE_TICKS=2, MAX_SNOOZE=1. Expect ring=0, snoozing=1, snooze_cnt=1. After 2 ticks expect ring=1. A second snooze ends the event to IDLE with snooze_cnt=0.
- stop and snooze asserted in the same cycle while ringing → IDLE. load_en=0 slot → no ring on match. load_idx ≥ N_ALARM → no slot changes.
- Assert rst mid-SNOOZE → all outputs 0 next cycle. Re-apply cmp equal to the old alarm value → no ring, because slots are cleared.

Source files
------------

// File: rtl/alarm_ring_multi.sv
// Multi-slot BCD alarm comparator with ring / snooze / dismiss control.
// Each armed slot is compared with the running time; a rising edge of a
// slot match starts a ring event (lowest index wins). The event rings for
// RING_TICKS ticks, may be snoozed up to MAX_SNOOZE times for SNOOZE_TICKS
// ticks each, and ends on stop, timeout or an over-limit snooze.
module alarm_ring_multi #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned N_ALARM      = 4,
  parameter int unsigned IDX_W        = 2,
  parameter int unsigned RING_TICKS   = 60,
  parameter int unsigned SNOOZE_TICKS = 300,
  parameter int unsigned MAX_SNOOZE   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [IDX_W-1:0]  load_idx,
  input  logic              load_en,
  input  logic [DATA_W-1:0] data_in_load,
  input  logic [DATA_W-1:0] data_in_cmp,
  input  logic              tick,
  input  logic              stop,
  input  logic              snooze,
  output logic              ring,
  output logic [IDX_W-1:0]  ring_idx,
  output logic [DATA_W-1:0] data_ring,
  output logic              snoozing,
  output logic [1:0]        snooze_cnt
);

  localparam int unsigned CNT_MAX = (RING_TICKS > SNOOZE_TICKS) ? RING_TICKS : SNOOZE_TICKS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_TICKS - 1);
  localparam logic [CNT_W-1:0] SNZ_LAST  = CNT_W'(SNOOZE_TICKS - 1);
  localparam logic [1:0]       SNZ_MAX   = 2'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RINGING,
    S_SNOOZE
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [1:0]          r_snz, w_snz_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic [DATA_W-1:0]   r_data, w_data_nxt;

  logic [DATA_W-1:0]   r_slot [N_ALARM];
  logic [N_ALARM-1:0]  r_armed;
  logic [N_ALARM-1:0]  r_match_prev;
  logic [N_ALARM-1:0]  w_match;
  logic [N_ALARM-1:0]  w_trig;
  logic [IDX_W-1:0]    w_win;
  logic [DATA_W-1:0]   w_win_data;

  // Slot storage: writes to indices outside the slot range match no slot
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_ALARM; i++) r_slot[i] <= '0;
      r_armed <= '0;
    end else if (load) begin
      for (int unsigned i = 0; i < N_ALARM; i++) begin
        if (load_idx == IDX_W'(i)) begin
          r_slot[i]  <= data_in_load;
          r_armed[i] <= load_en;
        end
      end
    end
  end

  // Per-slot match, rising-edge trigger and lowest-index winner select
  always_comb begin
    w_match    = '0;
    w_win      = '0;
    w_win_data = '0;
    for (int unsigned i = 0; i < N_ALARM; i++) begin
      w_match[i] = r_armed[i] && (r_slot[i] == data_in_cmp);
    end
    w_trig = w_match & ~r_match_prev;
    // Scan downward so the lowest triggering index is the last to assign
    for (int unsigned i = N_ALARM; i > 0; i--) begin
      if (w_trig[i-1]) begin
        w_win      = IDX_W'(i - 1);
        w_win_data = r_slot[i-1];
      end
    end
  end

  // Match history, updated every cycle regardless of ring state
  always_ff @(posedge clk) begin
    if (rst) r_match_prev <= '0;
    else     r_match_prev <= w_match;
  end

  // Ring controller state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_snz   <= '0;
      r_idx   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_snz   <= w_snz_nxt;
      r_idx   <= w_idx_nxt;
      r_data  <= w_data_nxt;
    end
  end

  // Next-state logic: stop beats snooze, both beat tick
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_snz_nxt   = r_snz;
    w_idx_nxt   = r_idx;
    w_data_nxt  = r_data;
    case (r_state)
      S_IDLE: begin
        if (|w_trig) begin
          w_state_nxt = S_RINGING;
          w_cnt_nxt   = '0;
          w_snz_nxt   = '0;
          w_idx_nxt   = w_win;
          w_data_nxt  = w_win_data;
        end
      end
      S_RINGING: begin
        if (stop || (snooze && (r_snz >= SNZ_MAX))) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_snz_nxt   = '0;
        end else if (snooze) begin
          w_state_nxt = S_SNOOZE;
          w_cnt_nxt   = '0;
          w_snz_nxt   = r_snz + 2'd1;
        end else if (tick) begin
          if (r_cnt == RING_LAST) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_snz_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      S_SNOOZE: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_snz_nxt   = '0;
        end else if (tick) begin
          if (r_cnt == SNZ_LAST) begin
            w_state_nxt = S_RINGING;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_snz_nxt   = '0;
      end
    endcase
  end

  assign ring       = (r_state == S_RINGING);
  assign snoozing   = (r_state == S_SNOOZE);
  assign ring_idx   = r_idx;
  assign data_ring  = r_data;
  assign snooze_cnt = r_snz;

endmodule
